spi_cs_ctrl: RTL and testbench

Transaction controller that sits directly upstream of the byte-level SPI master. It takes a byte count and a stream of bytes from a host and drives the master's byte handshake. It owns the active-low chip select, including setup, hold and inactive-gap timing. Every received byte is returned to the host with its index.

---
 rtl/spi_cs_ctrl.sv | 165 ++++++++++++++++
 tb/tb_spi_cs_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cs_ctrl.sv
// spi_cs_ctrl: transaction controller placed in front of a byte-level SPI master.
// It accepts a byte count and a stream of bytes from the host, hands each byte to
// the master through a one-cycle start pulse, and owns chip-select timing: setup
// before the first byte, hold after the last byte, and a minimum inactive gap.
// Every byte the master receives goes back to the host with its 0-based index.
//
// Ports:
//   i_Clk, i_Rst_L            clock (rising edge), asynchronous active-low reset
//   i_TX_Count                bytes in the transaction, sampled on the first byte
//   i_TX_Byte / i_TX_DV       host byte and its single-cycle valid pulse
//   o_TX_Ready                host handshake; a DV pulse counts only while this is high
//   o_RX_DV/o_RX_Byte/o_RX_Count  received byte pulse, data and index
//   o_SPI_CS_n                chip select, active low
//   o_ENG_TX_Byte/o_ENG_TX_DV byte and start pulse toward the SPI master
//   i_ENG_TX_Ready            SPI master idle
//   i_ENG_RX_DV/i_ENG_RX_Byte SPI master byte-done pulse and received byte
module spi_cs_ctrl #(
  parameter  int MAX_BYTES        = 2,
  parameter  int CS_SETUP_CLKS    = 2,
  parameter  int CS_HOLD_CLKS     = 2,
  parameter  int CS_INACTIVE_CLKS = 1,
  localparam int CNT_W            = $clog2(MAX_BYTES + 1)
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic [CNT_W-1:0] i_TX_Count,
  input  logic [7:0]       i_TX_Byte,
  input  logic             i_TX_DV,
  output logic             o_TX_Ready,
  output logic             o_RX_DV,
  output logic [7:0]       o_RX_Byte,
  output logic [CNT_W-1:0] o_RX_Count,
  output logic             o_SPI_CS_n,
  output logic [7:0]       o_ENG_TX_Byte,
  output logic             o_ENG_TX_DV,
  input  logic             i_ENG_TX_Ready,
  input  logic             i_ENG_RX_DV,
  input  logic [7:0]       i_ENG_RX_Byte
);

  localparam int TMR_SH  = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int TMR_MAX = (TMR_SH > CS_INACTIVE_CLKS) ? TMR_SH : CS_INACTIVE_CLKS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP_CLKS - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD_CLKS - 1);
  localparam logic [TMR_W-1:0] INACT_LAST = TMR_W'(CS_INACTIVE_CLKS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_BUSY, S_WAIT_TX, S_HOLD, S_INACTIVE
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [7:0]       eng_tx_byte_q, eng_tx_byte_d;
  logic             eng_tx_dv_q, eng_tx_dv_d;
  logic             cs_n_q, cs_n_d;
  logic             tx_ready_q, tx_ready_d;
  logic             rx_dv_q, rx_dv_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic [CNT_W-1:0] rx_count_q, rx_count_d;

  logic             accept;
  logic             rx_take;
  logic [CNT_W-1:0] count_clamped;

  assign accept  = i_TX_DV & tx_ready_q;
  assign rx_take = (state_q == S_BUSY) & i_ENG_RX_DV;

  always_comb begin
    if (i_TX_Count == '0)           count_clamped = CNT_W'(1);
    else if (i_TX_Count > MAX_CNT)  count_clamped = MAX_CNT;
    else                            count_clamped = i_TX_Count;
  end

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept)              state_d = S_SETUP;
      S_SETUP:    if (tmr_q == SETUP_LAST) state_d = S_BUSY;
      S_BUSY:     if (rx_take)             state_d = (rem_q <= CNT_W'(1)) ? S_HOLD : S_WAIT_TX;
      S_WAIT_TX:  if (accept)              state_d = S_BUSY;
      S_HOLD:     if (tmr_q == HOLD_LAST)  state_d = S_INACTIVE;
      S_INACTIVE: if (tmr_q == INACT_LAST) state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic. Registered outputs are computed from the next
  // state so that each one lands on the same cycle as the state it belongs to;
  // o_TX_Ready is the exception and deliberately lags the state by one cycle.
  always_comb begin
    tmr_d = '0;
    if ((state_d == state_q) && (state_q inside {S_SETUP, S_HOLD, S_INACTIVE}))
      tmr_d = tmr_q + 1'b1;

    rem_d         = rem_q;
    idx_d         = idx_q;
    eng_tx_byte_d = eng_tx_byte_q;
    if (accept) eng_tx_byte_d = i_TX_Byte;
    if ((state_q == S_IDLE) && accept) begin
      rem_d = count_clamped;
      idx_d = '0;
    end
    if (rx_take) begin
      if (rem_q != '0) rem_d = rem_q - 1'b1;
      idx_d = idx_q + 1'b1;
    end

    eng_tx_dv_d = ((state_d == S_SETUP) && (tmr_d == SETUP_LAST)) ||
                  ((state_q == S_WAIT_TX) && accept);
    cs_n_d      = !(state_d inside {S_SETUP, S_BUSY, S_WAIT_TX, S_HOLD});
    tx_ready_d  = !accept && ((state_q == S_IDLE) ||
                              ((state_q == S_WAIT_TX) && i_ENG_TX_Ready));

    rx_dv_d    = rx_take;
    rx_byte_d  = rx_take ? i_ENG_RX_Byte : rx_byte_q;
    rx_count_d = rx_take ? idx_q : rx_count_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tmr_q         <= '0;
      rem_q         <= '0;
      idx_q         <= '0;
      eng_tx_byte_q <= '0;
      eng_tx_dv_q   <= 1'b0;
      cs_n_q        <= 1'b1;
      tx_ready_q    <= 1'b0;
      rx_dv_q       <= 1'b0;
      rx_byte_q     <= '0;
      rx_count_q    <= '0;
    end else begin
      tmr_q         <= tmr_d;
      rem_q         <= rem_d;
      idx_q         <= idx_d;
      eng_tx_byte_q <= eng_tx_byte_d;
      eng_tx_dv_q   <= eng_tx_dv_d;
      cs_n_q        <= cs_n_d;
      tx_ready_q    <= tx_ready_d;
      rx_dv_q       <= rx_dv_d;
      rx_byte_q     <= rx_byte_d;
      rx_count_q    <= rx_count_d;
    end
  end

  assign o_TX_Ready    = tx_ready_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_RX_Byte     = rx_byte_q;
  assign o_RX_Count    = rx_count_q;
  assign o_SPI_CS_n    = cs_n_q;
  assign o_ENG_TX_Byte = eng_tx_byte_q;
  assign o_ENG_TX_DV   = eng_tx_dv_q;

endmodule

// File: tb/tb_spi_cs_ctrl.sv
// Testbench for spi_cs_ctrl: randomized host traffic and a behavioural SPI master,
// with expected waveforms derived from event times (accepts, master byte-done).
module tb_spi_cs_ctrl;
  localparam int MAXB  = 2;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int INACT = 1;
  localparam int CW    = $clog2(MAXB + 1);
  localparam int LOGN  = 8192;

  logic          i_Clk = 1'b0;
  logic          i_Rst_L = 1'b0;
  logic [CW-1:0] i_TX_Count = '0;
  logic [7:0]    i_TX_Byte = '0;
  logic          i_TX_DV = 1'b0;
  logic          o_TX_Ready;
  logic          o_RX_DV;
  logic [7:0]    o_RX_Byte;
  logic [CW-1:0] o_RX_Count;
  logic          o_SPI_CS_n;
  logic [7:0]    o_ENG_TX_Byte;
  logic          o_ENG_TX_DV;
  logic          i_ENG_TX_Ready = 1'b1;
  logic          i_ENG_RX_DV = 1'b0;
  logic [7:0]    i_ENG_RX_Byte = '0;

  spi_cs_ctrl #(
    .MAX_BYTES(MAXB), .CS_SETUP_CLKS(SETUP),
    .CS_HOLD_CLKS(HOLD), .CS_INACTIVE_CLKS(INACT)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L),
    .i_TX_Count(i_TX_Count), .i_TX_Byte(i_TX_Byte), .i_TX_DV(i_TX_DV),
    .o_TX_Ready(o_TX_Ready),
    .o_RX_DV(o_RX_DV), .o_RX_Byte(o_RX_Byte), .o_RX_Count(o_RX_Count),
    .o_SPI_CS_n(o_SPI_CS_n),
    .o_ENG_TX_Byte(o_ENG_TX_Byte), .o_ENG_TX_DV(o_ENG_TX_DV),
    .i_ENG_TX_Ready(i_ENG_TX_Ready),
    .i_ENG_RX_DV(i_ENG_RX_DV), .i_ENG_RX_Byte(i_ENG_RX_Byte)
  );

  always #5 i_Clk = ~i_Clk;

  int cyc = 0;
  always @(posedge i_Clk) cyc <= cyc + 1;

  // Per-cycle record of the outputs, indexed by cycle number
  bit            lg_cs[LOGN], lg_dv[LOGN], lg_rdy[LOGN], lg_rxdv[LOGN];
  logic [7:0]    lg_txb[LOGN], lg_rxb[LOGN];
  logic [CW-1:0] lg_rxc[LOGN];
  always @(negedge i_Clk) begin
    if (cyc < LOGN) begin
      lg_cs[cyc]   <= o_SPI_CS_n;
      lg_dv[cyc]   <= o_ENG_TX_DV;
      lg_rdy[cyc]  <= o_TX_Ready;
      lg_rxdv[cyc] <= o_RX_DV;
      lg_txb[cyc]  <= o_ENG_TX_Byte;
      lg_rxb[cyc]  <= o_RX_Byte;
      lg_rxc[cyc]  <= o_RX_Count;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural SPI master
  bit         eng_busy = 0;
  bit         eng_start = 0;
  int         eng_left = 0;
  int         rx_cyc_q[$];
  logic [7:0] rx_byte_q[$];
  logic [7:0] miso_q[$];

  logic [7:0]    last_rxb = '0;
  logic [CW-1:0] last_idx = '0;

  task automatic step();
    @(posedge i_Clk);
    #1;
    i_TX_DV     = 1'b0;
    i_ENG_RX_DV = 1'b0;
    if (eng_start) begin
      eng_start      = 0;
      eng_busy       = 1;
      i_ENG_TX_Ready = 1'b0;
      eng_left       = $urandom_range(2, 9);
    end else if (eng_busy) begin
      eng_left--;
      if (eng_left == 0) begin
        eng_busy       = 0;
        i_ENG_TX_Ready = 1'b1;
        i_ENG_RX_DV    = 1'b1;
        if (miso_q.size() > 0) i_ENG_RX_Byte = miso_q.pop_front();
        else                   i_ENG_RX_Byte = 8'($urandom);
        rx_cyc_q.push_back(cyc);
        rx_byte_q.push_back(i_ENG_RX_Byte);
      end
    end
    if (o_ENG_TX_DV) eng_start = 1;
  endtask

  // One transaction: host offers the clamped number of bytes, optionally
  // stalling before the second one and firing ignored DV pulses while not ready.
  task automatic run_txn(input int cnt, input logic [7:0] b0, input logic [7:0] b1,
                         input int stall1, input bit junk);
    int n, sent, stall_left, t_end, t0;
    int acc[MAXB];
    int rx[MAXB];
    logic [7:0] hb[MAXB];
    logic [7:0] mi[MAXB];
    bit done;
    hb[0] = b0;
    hb[1] = b1;
    n = (cnt == 0) ? 1 : ((cnt > MAXB) ? MAXB : cnt);
    rx_cyc_q.delete();
    rx_byte_q.delete();
    sent = 0; stall_left = 0; t_end = -1; done = 0;
    for (int g = 0; g < 400 && !done; g++) begin
      step();
      if (sent < n && o_TX_Ready) begin
        if (stall_left > 0) stall_left--;
        else begin
          i_TX_DV    = 1'b1;
          i_TX_Byte  = hb[sent];
          i_TX_Count = CW'(cnt);
          acc[sent]  = cyc;
          sent++;
          stall_left = stall1;
        end
      end else if (junk && !o_TX_Ready && $urandom_range(0, 2) == 0) begin
        i_TX_DV    = 1'b1;
        i_TX_Byte  = 8'($urandom);
        i_TX_Count = CW'($urandom);
      end
      if (sent == n && rx_cyc_q.size() >= n) begin
        if (t_end < 0) t_end = rx_cyc_q[n-1] + HOLD + INACT + 2;
        if (cyc >= t_end) done = 1;
      end
    end
    check_eq("txn_done", done, 1);
    if (!done) return;
    @(negedge i_Clk);
    #1;
    check_eq("master_bytes", rx_cyc_q.size(), n);
    for (int k = 0; k < n; k++) begin
      rx[k] = rx_cyc_q[k];
      mi[k] = rx_byte_q[k];
    end
    t0 = acc[0];
    for (int c = t0; c <= t_end && c < LOGN; c++) begin
      bit e_cs, e_dv, e_rdy, e_rx;
      int krx;
      e_cs  = !(c >= t0 + 1 && c <= rx[n-1] + HOLD);
      e_dv  = 0;
      e_rx  = 0;
      krx   = 0;
      e_rdy = (c == t0) || (c == t_end);
      for (int k = 0; k < n; k++) begin
        if ((k == 0 && c == t0 + SETUP) || (k > 0 && c == acc[k] + 1)) e_dv = 1;
        if (c == rx[k] + 1) begin e_rx = 1; krx = k; end
        if (k > 0 && c >= rx[k-1] + 2 && c <= acc[k]) e_rdy = 1;
      end
      check_eq($sformatf("cs_n@%0d", c), lg_cs[c], e_cs);
      check_eq($sformatf("eng_dv@%0d", c), lg_dv[c], e_dv);
      check_eq($sformatf("tx_ready@%0d", c), lg_rdy[c], e_rdy);
      check_eq($sformatf("rx_dv@%0d", c), lg_rxdv[c], e_rx);
      if (e_rx) begin
        check_eq($sformatf("rx_byte@%0d", c), lg_rxb[c], mi[krx]);
        check_eq($sformatf("rx_count@%0d", c), lg_rxc[c], krx);
      end
    end
    for (int k = 0; k < n; k++) begin
      int s, e;
      s = (k == 0) ? t0 + SETUP : acc[k] + 1;
      e = (k + 1 < n) ? acc[k+1] : t_end;
      for (int c = s; c <= e && c < LOGN; c++)
        check_eq($sformatf("eng_byte@%0d", c), lg_txb[c], hb[k]);
    end
    last_rxb = mi[n-1];
    last_idx = CW'(n - 1);
  endtask

  // Master byte-done pulse while idle must change nothing
  task automatic stray_rx();
    step();
    i_ENG_RX_DV   = 1'b1;
    i_ENG_RX_Byte = 8'($urandom);
    step();
    check_eq("stray_rx_dv", o_RX_DV, 0);
    check_eq("stray_rx_byte", o_RX_Byte, last_rxb);
    check_eq("stray_rx_count", o_RX_Count, last_idx);
    check_eq("stray_cs_n", o_SPI_CS_n, 1);
    check_eq("stray_ready", o_TX_Ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    repeat (2) @(posedge i_Clk);
    #2;
    check_eq("rst_cs_n", o_SPI_CS_n, 1);
    check_eq("rst_ready", o_TX_Ready, 0);
    check_eq("rst_rx_dv", o_RX_DV, 0);
    check_eq("rst_rx_byte", o_RX_Byte, 0);
    check_eq("rst_rx_count", o_RX_Count, 0);
    check_eq("rst_eng_dv", o_ENG_TX_DV, 0);
    check_eq("rst_eng_byte", o_ENG_TX_Byte, 0);
    i_Rst_L = 1'b1;
    step();
    check_eq("ready_after_rst", o_TX_Ready, 1);

    miso_q.push_back(8'h3C);
    run_txn(1, 8'hA5, 8'h00, 0, 0);
    check_eq("first_rx_byte", last_rxb, 8'h3C);
    run_txn(2, 8'h12, 8'h34, 0, 0);
    run_txn(0, 8'h5A, 8'h00, 0, 1);
    stray_rx();
    run_txn(3, 8'hC3, 8'h96, 0, 1);
    run_txn(1, 8'h77, 8'h00, 0, 1);
    run_txn(2, 8'hE1, 8'h1E, 50, 1);

    for (int i = 0; i < 25; i++) begin
      run_txn($urandom_range(0, 3), 8'($urandom), 8'($urandom), $urandom_range(0, 4), 1);
      if (i % 5 == 4) stray_rx();
    end

    // Reset while the master is busy with a byte
    got = 0;
    for (int g = 0; g < 20 && !got; g++) begin
      step();
      if (o_TX_Ready) begin
        i_TX_DV = 1'b1; i_TX_Byte = 8'h81; i_TX_Count = CW'(1);
        got = 1;
      end
    end
    check_eq("rst_txn_accept", got, 1);
    for (int g = 0; g < 20 && !eng_busy; g++) step();
    check_eq("rst_txn_busy", eng_busy, 1);
    check_eq("pre_rst_cs_n", o_SPI_CS_n, 0);
    #2 i_Rst_L = 1'b0;
    #1;
    check_eq("midrst_cs_n", o_SPI_CS_n, 1);
    check_eq("midrst_eng_dv", o_ENG_TX_DV, 0);
    check_eq("midrst_ready", o_TX_Ready, 0);
    check_eq("midrst_rx_dv", o_RX_DV, 0);
    eng_busy = 0; eng_start = 0; i_ENG_TX_Ready = 1'b1;
    repeat (2) @(posedge i_Clk);
    #2 i_Rst_L = 1'b1;
    step();
    check_eq("ready_after_midrst", o_TX_Ready, 1);
    last_rxb = '0;
    last_idx = '0;
    run_txn(1, 8'h42, 8'h00, 0, 0);
    check_eq("post_rst_index", last_idx, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
